// File: rtl/mac_pkg.sv
// Shared definitions for the half-precision MAC datapath: formats and the
// saturation limits of the 19-bit, radix-8 fixed-point domain.
package mac_pkg;

    localparam int FIXEDSIZE    = 19;
    localparam int RADIX        = 8;
    localparam int FLOATSIZE    = 16;
    localparam int MANTISSABITS = 10;
    localparam int EXPONENTBITS = 5;

    typedef logic signed [FIXEDSIZE-1:0] fix19_t;
    typedef logic        [FLOATSIZE-1:0] half_t;

    localparam fix19_t FIX_MAX = 19'sh1FFFF + 19'sh20000;
    localparam fix19_t FIX_MIN = 19'sh40000;

endpackage

// File: rtl/Fixed2Float.sv
// Signed fixed-point with RADIX fractional bits to float; mantissa bits
// below the available precision are truncated.
module Fixed2Float #(
    parameter int FIXEDSIZE    = mac_pkg::FIXEDSIZE,
    parameter int RADIX        = mac_pkg::RADIX,
    parameter int FLOATSIZE    = mac_pkg::FLOATSIZE,
    parameter int MANTISSABITS = mac_pkg::MANTISSABITS,
    parameter int EXPONENTBITS = mac_pkg::EXPONENTBITS
) (
    input  logic signed [FIXEDSIZE-1:0] in_fixed,
    output logic        [FLOATSIZE-1:0] out_float
);

    localparam int BIAS = (2 ** (EXPONENTBITS - 1)) - 1;

    logic                 sign;
    logic [FIXEDSIZE-1:0] mag;
    logic [FIXEDSIZE-1:0] norm;
    int                   lead;

    // The most negative input negates to itself, which read unsigned is
    // exactly its magnitude.
    always_comb begin
        sign = in_fixed[FIXEDSIZE-1];
        mag  = sign ? unsigned'(-in_fixed) : unsigned'(in_fixed);
        lead = 0;
        for (int i = 0; i < FIXEDSIZE; i++) begin
            lead = mag[i] ? i : lead;
        end
        norm = mag << (FIXEDSIZE - 1 - lead);
        if (mag == '0) begin
            out_float = '0;
        end else begin
            out_float = {sign, EXPONENTBITS'(lead - RADIX + BIAS),
                         norm[FIXEDSIZE-2 -: MANTISSABITS]};
        end
    end

endmodule

// File: rtl/Float2Fixed.sv
// Float to signed fixed-point with RADIX fractional bits. Truncates toward
// zero, flushes subnormals to zero, clamps out-of-range magnitudes.
module Float2Fixed #(
    parameter int FIXEDSIZE    = mac_pkg::FIXEDSIZE,
    parameter int RADIX        = mac_pkg::RADIX,
    parameter int FLOATSIZE    = mac_pkg::FLOATSIZE,
    parameter int MANTISSABITS = mac_pkg::MANTISSABITS,
    parameter int EXPONENTBITS = mac_pkg::EXPONENTBITS
) (
    input  logic        [FLOATSIZE-1:0] in_float,
    output logic signed [FIXEDSIZE-1:0] out_fixed,
    output logic                        out_exception,
    output logic                        out_overflow
);

    localparam int BIAS = (2 ** (EXPONENTBITS - 1)) - 1;
    localparam logic signed [FIXEDSIZE-1:0] SMAX = {1'b0, {(FIXEDSIZE-1){1'b1}}};
    localparam logic signed [FIXEDSIZE-1:0] SMIN = {1'b1, {(FIXEDSIZE-1){1'b0}}};

    logic                      sign;
    logic [EXPONENTBITS-1:0]   expo;
    logic [MANTISSABITS-1:0]   man;
    logic [MANTISSABITS:0]     sig;
    logic [FIXEDSIZE-1:0]      mag;
    int                        shift;
    int                        top_pos;

    // top_pos is where the hidden one lands; it must stay below the sign bit,
    // except for the single exactly-representable negative extreme.
    always_comb begin
        sign          = in_float[FLOATSIZE-1];
        expo          = in_float[FLOATSIZE-2 -: EXPONENTBITS];
        man           = in_float[MANTISSABITS-1:0];
        sig           = {1'b1, man};
        shift         = int'(expo) - BIAS - MANTISSABITS + RADIX;
        top_pos       = MANTISSABITS + shift;
        mag           = '0;
        out_fixed     = '0;
        out_exception = 1'b0;
        out_overflow  = 1'b0;
        if (expo == {EXPONENTBITS{1'b1}}) begin
            out_exception = 1'b1;
            out_fixed     = (man != '0) ? '0 : (sign ? SMIN : SMAX);
        end else if (expo == '0) begin
            out_fixed = '0;
        end else if (top_pos > FIXEDSIZE - 2) begin
            if (sign && (top_pos == FIXEDSIZE - 1) && (man == '0)) begin
                out_fixed = SMIN;
            end else begin
                out_overflow = 1'b1;
                out_fixed    = sign ? SMIN : SMAX;
            end
        end else begin
            if (shift >= 0) begin
                mag = FIXEDSIZE'(sig) << shift;
            end else begin
                mag = FIXEDSIZE'(sig) >> (-shift);
            end
            out_fixed = sign ? -$signed(mag) : $signed(mag);
        end
    end

endmodule

// File: rtl/sat_sub_fix.sv
// Signed fixed-point subtract a - b, clamped to the fixed-point range,
// with a flag raised whenever the clamp engages.
module sat_sub_fix
    import mac_pkg::*;
(
    input  fix19_t a,
    input  fix19_t b,
    output fix19_t diff,
    output logic   sat
);

    logic signed [FIXEDSIZE:0] wide;

    // One guard bit: the result overflowed when it disagrees with the sign bit.
    always_comb begin
        wide = {a[FIXEDSIZE-1], a} - {b[FIXEDSIZE-1], b};
        if (wide[FIXEDSIZE] != wide[FIXEDSIZE-1]) begin
            sat  = 1'b1;
            diff = wide[FIXEDSIZE] ? FIX_MIN : FIX_MAX;
        end else begin
            sat  = 1'b0;
            diff = wide[FIXEDSIZE-1:0];
        end
    end

endmodule

// File: rtl/delta_half.sv
// Streaming float16 differencer: emits each sample minus the previous sample
// of its group, computed in the accumulator's fixed-point domain.
module delta_half #(
    parameter int FIXEDSIZE    = mac_pkg::FIXEDSIZE,
    parameter int RADIX        = mac_pkg::RADIX,
    parameter int FLOATSIZE    = mac_pkg::FLOATSIZE,
    parameter int MANTISSABITS = mac_pkg::MANTISSABITS,
    parameter int EXPONENTBITS = mac_pkg::EXPONENTBITS
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 v,
    input  logic                 n,
    input  logic [FLOATSIZE-1:0] x,
    output logic [FLOATSIZE-1:0] r,
    output logic                 r_valid,
    output logic                 r_first,
    output logic                 r_exc
);

    logic signed [FIXEDSIZE-1:0] x_fixed, diff;
    logic                        x_exc, x_ovf, sat;
    logic        [FLOATSIZE-1:0] delta_float;

    logic signed [FIXEDSIZE-1:0] cur1_d, cur1_q, prev_d, prev_q, delta_d, delta_q;
    logic                        v1_d, v1_q, n1_d, n1_q, exc1_d, exc1_q;
    logic                        v2_d, v2_q, n2_d, n2_q, exc2_d, exc2_q;
    logic        [FLOATSIZE-1:0] r_d, r_q;
    logic                        r_valid_d, r_valid_q, r_first_d, r_first_q, r_exc_d, r_exc_q;

    Float2Fixed #(
        .FIXEDSIZE(FIXEDSIZE), .RADIX(RADIX), .FLOATSIZE(FLOATSIZE),
        .MANTISSABITS(MANTISSABITS), .EXPONENTBITS(EXPONENTBITS)
    ) u_f2x (
        .in_float(x), .out_fixed(x_fixed), .out_exception(x_exc), .out_overflow(x_ovf)
    );

    sat_sub_fix u_sub (.a(cur1_q), .b(prev_q), .diff(diff), .sat(sat));

    Fixed2Float #(
        .FIXEDSIZE(FIXEDSIZE), .RADIX(RADIX), .FLOATSIZE(FLOATSIZE),
        .MANTISSABITS(MANTISSABITS), .EXPONENTBITS(EXPONENTBITS)
    ) u_x2f (
        .in_fixed(delta_q), .out_float(delta_float)
    );

    // Next-state for all three stages; stage 2 freezes on bubbles so prev and
    // the last delta survive gaps in the stream.
    always_comb begin
        cur1_d = x_fixed;
        v1_d   = v;
        n1_d   = n & v;
        exc1_d = v & (x_exc | x_ovf);
        if (v1_q) begin
            v2_d   = 1'b1;
            n2_d   = n1_q;
            prev_d = cur1_q;
            if (n1_q) begin
                delta_d = cur1_q;
                exc2_d  = exc1_q;
            end else begin
                delta_d = diff;
                exc2_d  = exc1_q | sat;
            end
        end else begin
            v2_d    = 1'b0;
            n2_d    = n2_q;
            prev_d  = prev_q;
            delta_d = delta_q;
            exc2_d  = exc2_q;
        end
        if (v2_q) begin
            r_d = delta_float;
        end else begin
            r_d = r_q;
        end
        r_valid_d = v2_q;
        r_first_d = n2_q & v2_q;
        r_exc_d   = exc2_q & v2_q;
    end

    // Pipeline registers; every one clears on reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cur1_q    <= '0;
            v1_q      <= 1'b0;
            n1_q      <= 1'b0;
            exc1_q    <= 1'b0;
            prev_q    <= '0;
            delta_q   <= '0;
            v2_q      <= 1'b0;
            n2_q      <= 1'b0;
            exc2_q    <= 1'b0;
            r_q       <= '0;
            r_valid_q <= 1'b0;
            r_first_q <= 1'b0;
            r_exc_q   <= 1'b0;
        end else begin
            cur1_q    <= cur1_d;
            v1_q      <= v1_d;
            n1_q      <= n1_d;
            exc1_q    <= exc1_d;
            prev_q    <= prev_d;
            delta_q   <= delta_d;
            v2_q      <= v2_d;
            n2_q      <= n2_d;
            exc2_q    <= exc2_d;
            r_q       <= r_d;
            r_valid_q <= r_valid_d;
            r_first_q <= r_first_d;
            r_exc_q   <= r_exc_d;
        end
    end

    assign r       = r_q;
    assign r_valid = r_valid_q;
    assign r_first = r_first_q;
    assign r_exc   = r_exc_q;

endmodule

// File: tb/tb_delta_half.sv
// Directed bench for delta_half: expected results are queued as samples are
// driven and retired when the DUT produces them, three edges later.
module tb_delta_half;

    logic        clock = 1'b0;
    logic        resetn;
    logic        v;
    logic        n;
    logic [15:0] x;
    logic [15:0] r;
    logic        r_valid, r_first, r_exc;

    typedef struct {
        logic [15:0] r;
        logic        first;
        logic        exc;
        logic        chk_r;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [15:0] last_r = 16'h0000;

    delta_half dut (
        .clock(clock), .resetn(resetn), .v(v), .n(n), .x(x),
        .r(r), .r_valid(r_valid), .r_first(r_first), .r_exc(r_exc)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic observe();
        exp_t e;
        logic exp_valid;
        exp_valid = (sb.size() > 0) && (sb[0].due == cyc);
        check("r_valid", {31'd0, r_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            e = sb.pop_front();
            if (e.chk_r) check("r", {16'd0, r}, {16'd0, e.r});
            check("r_first", {31'd0, r_first}, {31'd0, e.first});
            check("r_exc", {31'd0, r_exc}, {31'd0, e.exc});
        end else begin
            check("r_hold", {16'd0, r}, {16'd0, last_r});
            check("r_first_idle", {31'd0, r_first}, 32'd0);
            check("r_exc_idle", {31'd0, r_exc}, 32'd0);
        end
        last_r = r;
    endtask

    // One cycle: drive inputs, queue the expectation, advance, then check.
    task automatic step(input logic iv, input logic in, input logic [15:0] ix,
                        input logic [15:0] er, input logic ef, input logic ee,
                        input logic ck);
        exp_t e;
        v = iv;
        n = in;
        x = ix;
        if (iv) begin
            e = '{er, ef, ee, ck, cyc + 3};
            sb.push_back(e);
        end
        @(posedge clock);
        cyc++;
        #1;
        observe();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        v      = 1'b0;
        n      = 1'b0;
        x      = 16'h0000;
        repeat (2) @(posedge clock);
        #1;
        check("reset_r", {16'd0, r}, 32'd0);
        check("reset_r_valid", {31'd0, r_valid}, 32'd0);
        check("reset_r_first", {31'd0, r_first}, 32'd0);
        check("reset_r_exc", {31'd0, r_exc}, 32'd0);
        resetn = 1'b1;

        // basic differencing: 1.0, 3.0, 2.5
        step(1'b1, 1'b1, 16'h3C00, 16'h3C00, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'h4200, 16'h4000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'h4100, 16'hB800, 1'b0, 1'b0, 1'b1);
        idle(3);

        // group continues from 2.5, then restarts at -1.0
        step(1'b1, 1'b0, 16'h3C00, 16'hBE00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'h4000, 16'h3C00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 16'hBC00, 16'hBC00, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'h3800, 16'h3E00, 1'b0, 1'b0, 1'b1);

        // one-sample groups pass through
        step(1'b1, 1'b1, 16'h4500, 16'h4500, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 16'hC000, 16'hC000, 1'b1, 1'b0, 1'b1);
        idle(3);

        // bubbles with garbage n/x must not open a group
        step(1'b1, 1'b1, 16'h4000, 16'h4000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h7BFF, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h4200, 16'h3C00, 1'b0, 1'b0, 1'b1);
        idle(3);

        // saturation, then prev tracks the unsaturated input
        step(1'b1, 1'b1, 16'h63D0, 16'h63D0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'hE3D0, 16'hE400, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 16'hE3D0, 16'h0000, 1'b0, 1'b0, 1'b1);
        idle(3);

        // exceptions: +inf, out-of-range 2048.0, and exact -1024.0 boundary
        step(1'b1, 1'b1, 16'h7C00, 16'h0000, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'h3800, 16'h3800, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 16'h6800, 16'h0000, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'hE400, 16'hE400, 1'b1, 1'b0, 1'b1);
        idle(3);

        // reset with two samples in flight
        step(1'b1, 1'b1, 16'h3C00, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
        v      = 1'b0;
        resetn = 1'b0;
        #1;
        check("midrst_r", {16'd0, r}, 32'd0);
        check("midrst_r_valid", {31'd0, r_valid}, 32'd0);
        check("midrst_r_first", {31'd0, r_first}, 32'd0);
        check("midrst_r_exc", {31'd0, r_exc}, 32'd0);
        sb.delete();
        last_r = 16'h0000;
        idle(2);
        resetn = 1'b1;
        idle(2);
        step(1'b1, 1'b0, 16'h4000, 16'h4000, 1'b0, 1'b0, 1'b1);
        idle(4);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
